fp_mul_pipe: RTL and testbench

Pipelined, parameterised fixed-point multiplier: the streaming successor to the combinational fixed-point multiplier in the arithmetic library. Each operand has its own Ix.Fx format and per-transaction signedness. Each transaction selects a rounding mode, and the block returns a saturated Io.Fo result with overflow, underflow and inexact flags. It sits between valid/ready producers and consumers in datapath blocks and carries a saturating overflow event counter for status registers.

---
 rtl/fp_mul_pipe_if.sv | 31 +++
 rtl/fp_mul_pipe.sv | 163 ++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pipe_if.sv
// Valid/ready operand and result channels of the fixed-point multiplier pipe.
interface fp_mul_pipe_if #(
  parameter int AW = 16,
  parameter int BW = 16,
  parameter int CW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] a;
  logic          s1;
  logic [BW-1:0] b;
  logic          s2;
  logic [1:0]    rnd;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] c;
  logic          sign;
  logic          overflow;
  logic          underflow;
  logic          inexact;

  modport slave (
    input  in_valid, a, s1, b, s2, rnd, out_ready,
    output in_ready, out_valid, c, sign, overflow, underflow, inexact
  );

  modport master (
    output in_valid, a, s1, b, s2, rnd, out_ready,
    input  in_ready, out_valid, c, sign, overflow, underflow, inexact
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Streaming fixed-point multiplier: Ix.Fx operands, per-transaction signedness
// and rounding mode, saturated Io.Fo result with flags and an overflow counter.
module fp_mul_pipe #(
  parameter int I1    = 2,
  parameter int F1    = 14,
  parameter int I2    = 2,
  parameter int F2    = 14,
  parameter int I3    = 2,
  parameter int F3    = 14,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_mul_pipe_if.slave     bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt
);
  localparam int AW     = I1 + F1;
  localparam int BW     = I2 + F2;
  localparam int CW     = I3 + F3;
  localparam int PW     = AW + BW + 1;
  localparam int D      = F1 + F2 - F3;
  localparam int XW     = (PW + 1 > CW + 2) ? PW + 1 : CW + 2;
  localparam int STAGES = 4;

  if (F3 > F1 + F2 || I3 + F3 < 2) begin : g_bad_fmt
    $error("fp_mul_pipe: illegal result format");
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          s1;
    logic          s2;
    logic [1:0]    rnd;
  } st1_t;

  typedef struct packed {
    logic [PW-1:0] p;
    logic          sgn;
    logic [1:0]    rnd;
  } st2_t;

  typedef struct packed {
    logic [XW-1:0] r;
    logic          sgn;
    logic          nz;
    logic          frac;
  } st3_t;

  typedef struct packed {
    logic [CW-1:0] c;
    logic          sgn;
    logic          ovf;
    logic          unf;
    logic          inex;
  } st4_t;

  localparam logic signed [XW-1:0] ONE  = XW'(1);
  localparam logic signed [XW-1:0] SMAX = (ONE <<< (CW - 1)) - ONE;
  localparam logic signed [XW-1:0] SMIN = -(ONE <<< (CW - 1));
  localparam logic signed [XW-1:0] UMAX = (ONE <<< CW) - ONE;

  logic [STAGES:1] vld_pipe;
  logic            en, acc;
  st1_t            st1;
  st2_t            st2;
  st3_t            st3;
  st4_t            st4;

  // The whole pipe, bubbles included, freezes while the output is held.
  assign en           = !(vld_pipe[STAGES] && !bus.out_ready);
  assign acc          = bus.in_valid && en;
  assign bus.in_ready = en;

  // Exact product: each operand extended by its own signedness.
  logic signed [AW:0]   ax;
  logic signed [BW:0]   bx;
  logic signed [PW-1:0] ae, be, p2;
  assign ax = $signed({st1.s1 & st1.a[AW-1], st1.a});
  assign bx = $signed({st1.s2 & st1.b[BW-1], st1.b});
  assign ae = PW'(ax);
  assign be = PW'(bx);
  assign p2 = ae * be;

  logic signed [XW-1:0] pe, r3;
  logic                 frac3;
  assign pe = XW'($signed(st2.p));

  if (D == 0) begin : g_exact
    assign r3    = pe;
    assign frac3 = 1'b0;
  end else begin : g_round
    localparam logic [D-1:0] HALF = D'(1) << (D - 1);
    logic signed [XW-1:0] q;
    logic [D-1:0]         rem;
    logic                 up;
    assign q   = pe >>> D;
    assign rem = st2.p[D-1:0];
    always_comb begin
      case (st2.rnd)
        2'd1:    up = (rem >= HALF);
        2'd2:    up = (rem > HALF) || (rem == HALF && q[0]);
        default: up = 1'b0;
      endcase
    end
    assign r3    = q + $signed({{(XW-1){1'b0}}, up});
    assign frac3 = |rem;
  end

  logic signed [XW-1:0] rr;
  logic [CW-1:0]        c4;
  logic                 ovf4;
  assign rr = $signed(st3.r);

  always_comb begin
    ovf4 = 1'b0;
    c4   = rr[CW-1:0];
    if (st3.sgn) begin
      if (rr > SMAX)      begin ovf4 = 1'b1; c4 = SMAX[CW-1:0]; end
      else if (rr < SMIN) begin ovf4 = 1'b1; c4 = SMIN[CW-1:0]; end
    end else begin
      if (rr > UMAX)      begin ovf4 = 1'b1; c4 = UMAX[CW-1:0]; end
      else if (rr < 0)    begin ovf4 = 1'b1; c4 = '0; end
    end
  end

  // Rounding and saturation are registered separately so a result emerges
  // three edges after its operands are accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      st1      <= '0;
      st2      <= '0;
      st3      <= '0;
      st4      <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], acc};
      st1      <= '{a: bus.a, b: bus.b, s1: bus.s1, s2: bus.s2, rnd: bus.rnd};
      st2      <= '{p: p2, sgn: st1.s1 | st1.s2, rnd: st1.rnd};
      st3      <= '{r: r3, sgn: st2.sgn, nz: |st2.p, frac: frac3};
      st4      <= '{c: c4, sgn: st3.sgn, ovf: ovf4,
                    unf: st3.nz && !ovf4 && (rr == '0),
                    inex: st3.frac || ovf4};
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.c         = st4.c;
  assign bus.sign      = st4.sgn;
  assign bus.overflow  = st4.ovf;
  assign bus.underflow = st4.unf;
  assign bus.inexact   = st4.inex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_cnt <= '0;
    else if (cnt_clr)
      ovf_cnt <= '0;
    else if (bus.out_valid && bus.out_ready && st4.ovf && !(&ovf_cnt))
      ovf_cnt <= ovf_cnt + 1'b1;
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: driver pushes model results, negedge monitor checks.
module tb_fp_mul_pipe;
  localparam int I1 = 2, F1 = 14, I2 = 2, F2 = 14, I3 = 2, F3 = 14, CNT_W = 4;
  localparam int AW = I1 + F1, BW = I2 + F2, CW = I3 + F3;
  localparam int LAT = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] ovf_cnt;

  always #5 clk = ~clk;

  fp_mul_pipe_if #(.AW(AW), .BW(BW), .CW(CW)) bus ();

  fp_mul_pipe #(.I1(I1), .F1(F1), .I2(I2), .F2(F2), .I3(I3), .F3(F3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt)
  );

  typedef struct {
    logic [CW-1:0] c;
    logic          sign, ovf, unf, inex;
    int            acc, stl;
  } exp_t;

  exp_t q[$];
  int   checks = 0, fails = 0, cyc = 0, stalls = 0, model_cnt = 0;
  bit   seen = 0, prev_stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact integer product, floor division, explicit tie handling, clamp.
  function automatic exp_t model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                 input logic s1, input logic s2, input logic [1:0] rnd);
    exp_t   e;
    longint pa, pb, p, qq, rem, r, lo, hi, half;
    int     d;
    d  = F1 + F2 - F3;
    pa = s1 ? longint'($signed(a)) : longint'(a);
    pb = s2 ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    if (d == 0) begin
      r = p; rem = 0;
    end else begin
      qq   = p >>> d;
      rem  = p - (qq <<< d);
      half = 64'sd1 <<< (d - 1);
      case (rnd)
        2'd1:    r = (rem >= half) ? qq + 1 : qq;
        2'd2:    r = (rem > half || (rem == half && qq[0])) ? qq + 1 : qq;
        default: r = qq;
      endcase
    end
    e.sign = s1 | s2;
    lo = e.sign ? -(64'sd1 <<< (CW - 1)) : 64'sd0;
    hi = e.sign ? (64'sd1 <<< (CW - 1)) - 1 : (64'sd1 <<< CW) - 1;
    e.ovf = (r > hi) || (r < lo);
    e.c   = CW'(r > hi ? hi : (r < lo ? lo : r));
    e.inex = (rem != 0) || e.ovf;
    e.unf  = (p != 0) && !e.ovf && (r == 0);
    e.acc = 0; e.stl = 0;
    return e;
  endfunction

  task automatic send(input logic [AW-1:0] ta, input logic [BW-1:0] tb2,
                      input logic ts1, input logic ts2, input logic [1:0] tr);
    bit   ok;
    int   w;
    exp_t e;
    bus.a = ta; bus.b = tb2; bus.s1 = ts1; bus.s2 = ts2; bus.rnd = tr;
    bus.in_valid = 1'b1;
    ok = 0; w = 0;
    while (!ok && w < 200) begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); w++;
    end
    #1;
    if (ok) begin
      e = model(ta, tb2, ts1, ts2, tr);
      e.acc = cyc; e.stl = stalls;
      q.push_back(e);
    end else begin
      checks++; fails++;
      $display("FAIL send_timeout: in_ready never seen, required within 200 cycles");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 300) begin @(negedge clk); w++; end
    if (q.size() != 0) begin
      checks++; fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compares every presented result; pops on handshake.
  always @(negedge clk) begin
    exp_t h;
    bit   pop_ovf;
    pop_ovf = 0;
    if (!rst_n) begin
      q.delete(); seen = 0; model_cnt = 0; prev_stall = 0;
    end else begin
      chk("ovf_cnt", 64'(ovf_cnt), 64'(model_cnt));
      chk("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
      if (prev_stall) chk("hold_valid", 64'(bus.out_valid), 64'd1);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(bus.out_valid), 64'd0);
        end else begin
          h = q[0];
          if (!seen) begin
            chk("latency", 64'(cyc - h.acc - (stalls - h.stl)), 64'(LAT));
            seen = 1;
          end
          chk("result", {bus.c, bus.sign, bus.overflow, bus.underflow, bus.inexact},
                        {h.c, h.sign, h.ovf, h.unf, h.inex});
          if (bus.out_ready) begin
            pop_ovf = h.ovf;
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
      if (cnt_clr) model_cnt = 0;
      else if (pop_ovf && model_cnt < (1 << CNT_W) - 1) model_cnt++;
      prev_stall = bus.out_valid && !bus.out_ready;
      if (prev_stall) stalls++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit done;

  initial begin
    bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.s1 = 0; bus.s2 = 0; bus.rnd = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_payload", {bus.c, bus.sign, bus.overflow, bus.underflow, bus.inexact}, 64'd0);
    chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: saturation, unsigned path, rounding modes, mixed sign, reserved mode.
    send(16'h6000, 16'h6000, 1, 1, 2'd0);
    send(16'hC000, 16'hC000, 1, 1, 2'd0);
    send(16'h6000, 16'h6000, 0, 0, 2'd0);
    send(16'hFFFF, 16'hFFFF, 0, 0, 2'd0);
    for (int r = 0; r < 4; r++) send(16'h0001, 16'h2000, 0, 0, 2'(r));
    send(16'h0003, 16'h2000, 0, 0, 2'd2);
    send(16'hFFFF, 16'h2000, 1, 1, 2'd0);
    send(16'hFFFF, 16'h2000, 1, 1, 2'd1);
    send(16'hFFFF, 16'h2000, 1, 1, 2'd2);
    send(16'h8000, 16'hFFFF, 1, 0, 2'd1);
    send(16'h8000, 16'h8000, 1, 1, 2'd0);
    drain();

    // Backpressure: six back-to-back, out_ready low for cycles 4-8.
    fork
      for (int i = 0; i < 6; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      begin
        repeat (3) @(posedge clk); #1; bus.out_ready = 1'b0;
        repeat (5) @(posedge clk); #1; bus.out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random input gaps and output backpressure.
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
        end
        done = 1;
      end
      while (!done) begin
        @(posedge clk); #1; bus.out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Counter saturation, then clear colliding with an overflowing accept.
    for (int i = 0; i < (1 << CNT_W) + 2; i++) send(16'h6000, 16'h6000, 1, 1, 2'd0);
    drain();
    chk("ovf_cnt_sat", 64'(ovf_cnt), 64'hF);
    send(16'h6000, 16'h6000, 1, 1, 2'd0);
    for (int w = 0; w < 10 && !bus.out_valid; w++) begin @(posedge clk); #1; end
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("ovf_cnt_clr", 64'(ovf_cnt), 64'd0);
    drain();

    // Reset with three transactions in flight.
    send(16'h6000, 16'h6000, 1, 1, 2'd0);
    send(16'h1234, 16'h5678, 0, 0, 2'd1);
    send(16'hFFFF, 16'hFFFF, 0, 0, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_flags", {bus.c, bus.sign, bus.overflow, bus.underflow, bus.inexact}, 64'd0);
    chk("midrst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(bus.out_valid), 64'd0);
    send(16'h4000, 16'h2000, 1, 0, 2'd2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
